// File: rtl/nx_fifo_wr_arb.sv
// nx_fifo_wr_arb: round-robin write-port arbiter sharing one FIFO among NREQ producers
//
// Locked bursts of up to MAX_BURST beats, zero-latency accept, FIFO full
// backpressure, a two-cycle clear sequence and a sticky overflow flag.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req, req_last         per-requester beat valid / end-of-burst marker
//   req_data              packed beat data, requester i at [i*DW +: DW]
//   gnt                   per-requester accept (combinational, one-hot or zero)
//   clear_req, clear_done flush request in, single-cycle completion pulse out
//   fifo_full/overflow    FIFO status in
//   fifo_wen/wdata/clear  FIFO write strobe, data and clear out
//   owner                 current or last grant holder
//   busy                  high while in BURST or CLEAR
//   err_overflow          sticky overflow flag
module nx_fifo_wr_arb #(
    parameter int NREQ      = 4,
    parameter int DW        = 1,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          gnt,
    input  logic                     clear_req,
    output logic                     clear_done,
    input  logic                     fifo_full,
    input  logic                     fifo_overflow,
    output logic                     fifo_wen,
    output logic [DW-1:0]            fifo_wdata,
    output logic                     fifo_clear,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy,
    output logic                     err_overflow
);
    localparam int PW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, BURST, CLEAR} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d, owner_q, owner_d, win;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            clear_done_q, clear_done_d, err_q, err_d, found, acc;
    logic [NREQ-1:0] rot, gnt_c;
    logic [DW-1:0]   wdata;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] x);
        return (x == PW'(NREQ - 1)) ? '0 : x + 1'b1;
    endfunction

    // Requests rotated so bit k corresponds to requester (rr_ptr + k) mod NREQ.
    assign rot = NREQ'({req, req} >> rr_ptr_q);

    // Descending scan with overwrite leaves the lowest rotated offset as winner.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k]) begin
                found = 1'b1;
                win   = PW'((int'(rr_ptr_q) + k) % NREQ);
            end
    end

    // Grants are blocked by reset, a pending clear and FIFO full.
    always_comb begin
        gnt_c = '0;
        if (rst_n && !clear_req && !fifo_full) begin
            if (state_q == IDLE && found) gnt_c[win] = 1'b1;
            else if (state_q == BURST)    gnt_c[owner_q] = req[owner_q];
        end
    end

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt_c[i]) wdata = req_data[i*DW +: DW];
    end

    assign acc = |(req & gnt_c);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        beat_cnt_d   = beat_cnt_q;
        clear_done_d = 1'b0;
        err_d        = err_q | fifo_overflow;
        if (state_q == CLEAR) begin
            state_d      = IDLE;
            rr_ptr_d     = '0;
            beat_cnt_d   = '0;
            clear_done_d = 1'b1;
            err_d        = fifo_overflow;
        end else if (clear_req) begin
            state_d = CLEAR;
        end else if (state_q == IDLE) begin
            if (acc) begin
                owner_d = win;
                if (req_last[win] || MAX_BURST == 1) begin
                    rr_ptr_d = inc(win);
                end else begin
                    beat_cnt_d = BW'(1);
                    state_d    = BURST;
                end
            end
        end else if (acc) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (req_last[owner_q] || beat_cnt_q + 1'b1 == BW'(MAX_BURST)) begin
                state_d  = IDLE;
                rr_ptr_d = inc(owner_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            beat_cnt_q   <= '0;
            clear_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            beat_cnt_q   <= beat_cnt_d;
            clear_done_q <= clear_done_d;
            err_q        <= err_d;
        end
    end

    assign gnt          = gnt_c;
    assign fifo_wen     = acc;
    assign fifo_wdata   = wdata;
    assign fifo_clear   = (state_q == CLEAR);
    assign busy         = (state_q != IDLE);
    assign clear_done   = clear_done_q;
    assign owner        = owner_q;
    assign err_overflow = err_q;
endmodule

// File: tb/tb_nx_fifo_wr_arb.sv
// tb_nx_fifo_wr_arb: scenario tasks for the FIFO write arbiter with a per-cycle scoreboard
module tb_nx_fifo_wr_arb;
    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NREQ-1:0]   req = '0, req_last = '0, gnt;
    logic [NREQ*DW-1:0] req_data = '0;
    logic              clear_req = 1'b0, fifo_full = 1'b0, fifo_overflow = 1'b0;
    logic              clear_done, fifo_wen, fifo_clear, busy, err_overflow;
    logic [DW-1:0]     fifo_wdata;
    logic [1:0]        owner;
    int                checks = 0, errors = 0, cyc = 0;
    // Entry: {gnt, wen, wdata, fifo_clear, clear_done, busy, err_overflow}
    logic [16:0]       sb[$];

    always #5 clk = ~clk;

    nx_fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_last(req_last), .req_data(req_data),
        .gnt(gnt), .clear_req(clear_req), .clear_done(clear_done), .fifo_full(fifo_full),
        .fifo_overflow(fifo_overflow), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata),
        .fifo_clear(fifo_clear), .owner(owner), .busy(busy), .err_overflow(err_overflow)
    );

    // Applies one cycle of stimulus, pushes its expected outputs, and stops mid-cycle.
    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic f, input logic k,
                         input logic o, input logic [3:0] eg, input logic [3:0] fl);
        logic [7:0] d;
        @(posedge clk);
        #1;
        cyc++;
        d = '0;
        req = r; req_last = l; fifo_full = f; clear_req = k; fifo_overflow = o;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DW +: DW] = {cyc[3:0], 4'(i)};
            if (eg[i]) d = {cyc[3:0], 4'(i)};
        end
        sb.push_back({eg, |eg, d, fl});
        @(negedge clk);
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 1'b0;
        req = '0; req_last = '0; fifo_full = 1'b0; clear_req = 1'b0; fifo_overflow = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        #1;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow, owner} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b wen=%b wd=%h clr=%b done=%b busy=%b err=%b own=%0d required all 0",
                     gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow, owner);
        end
        req = 4'hf;
        #1;
        checks++;
        if (gnt !== 4'b0 || fifo_wen !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt_blocked got gnt=%b wen=%b required 0000/0", gnt, fifo_wen);
        end
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fairness;
        logic [16:0] e;
        logic [3:0]  g;
        apply_reset();
        g = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            drive(4'hf, 4'hf, 1'b0, 1'b0, 1'b0, g, 4'h0);
            e = sb.pop_front();
            checks++;
            if ({gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow} !== e) begin
                errors++;
                $display("FAIL fairness c%0d got %h (gnt=%b wd=%h) required %h", c,
                         {gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow}, gnt, fifo_wdata, e);
            end
            g = {g[2:0], g[3]};
        end
        checks++;
        if (owner !== 2'd2) begin
            errors++;
            $display("FAIL fairness_owner got %0d required 2", owner);
        end
    endtask

    // Rows: {req, req_last, full, clear, overflow, expected gnt, {fclr, cdone, busy, err}}
    task automatic test_burst_lock;
        logic [16:0] e;
        logic [18:0] t[9];
        t = '{19'b0101_0000_0_0_0_0001_0000, 19'b0101_0000_0_0_0_0001_0010,
              19'b0101_0000_0_0_0_0001_0010, 19'b0101_0000_0_0_0_0001_0010,
              19'b0101_0000_0_0_0_0100_0000, 19'b0101_0000_0_0_0_0100_0010,
              19'b0101_0000_0_0_0_0100_0010, 19'b0101_0000_0_0_0_0100_0010,
              19'b0000_0000_0_0_0_0000_0000};
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            drive(t[c][18:15], t[c][14:11], t[c][10], t[c][9], t[c][8], t[c][7:4], t[c][3:0]);
            e = sb.pop_front();
            checks++;
            if ({gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow} !== e) begin
                errors++;
                $display("FAIL burst_lock c%0d got %h (gnt=%b) required %h", c,
                         {gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow}, gnt, e);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [16:0] e;
        logic [18:0] t[9];
        t = '{19'b0101_0000_1_0_0_0000_0000, 19'b0101_0000_0_0_0_0001_0000,
              19'b0101_0000_0_0_0_0001_0010, 19'b0101_0000_1_0_0_0000_0010,
              19'b0101_0000_1_0_0_0000_0010, 19'b0101_0000_1_0_0_0000_0010,
              19'b0101_0000_0_0_0_0001_0010, 19'b0101_0000_0_0_0_0001_0010,
              19'b0101_0000_0_0_0_0100_0000};
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            drive(t[c][18:15], t[c][14:11], t[c][10], t[c][9], t[c][8], t[c][7:4], t[c][3:0]);
            e = sb.pop_front();
            checks++;
            if ({gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow} !== e) begin
                errors++;
                $display("FAIL backpressure c%0d got %h (gnt=%b) required %h", c,
                         {gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow}, gnt, e);
            end
            if (c == 4) begin
                checks++;
                if (owner !== 2'd0) begin
                    errors++;
                    $display("FAIL backpressure_owner got %0d required 0", owner);
                end
            end
        end
    endtask

    task automatic test_early_last;
        logic [16:0] e;
        logic [18:0] t[6];
        t = '{19'b1010_0000_0_0_0_0010_0000, 19'b1010_0010_0_0_0_0010_0010,
              19'b1010_0000_0_0_0_1000_0000, 19'b0010_0000_0_0_0_0000_0010,
              19'b1010_1000_0_0_0_1000_0010, 19'b1010_1010_0_0_0_0010_0000};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            drive(t[c][18:15], t[c][14:11], t[c][10], t[c][9], t[c][8], t[c][7:4], t[c][3:0]);
            e = sb.pop_front();
            checks++;
            if ({gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow} !== e) begin
                errors++;
                $display("FAIL early_last c%0d got %h (gnt=%b) required %h", c,
                         {gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow}, gnt, e);
            end
        end
    endtask

    task automatic test_clear_abort;
        logic [16:0] e;
        logic [18:0] t[8];
        t = '{19'b0001_0001_0_0_0_0001_0000, 19'b0100_0000_0_0_0_0100_0000,
              19'b0100_0000_0_1_0_0000_0010, 19'b0100_0000_0_0_0_0000_1010,
              19'b0011_0000_0_1_0_0000_0100, 19'b0011_0000_0_1_0_0000_1010,
              19'b0011_0000_0_0_0_0001_0100, 19'b0011_0000_0_0_0_0001_0010};
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            drive(t[c][18:15], t[c][14:11], t[c][10], t[c][9], t[c][8], t[c][7:4], t[c][3:0]);
            e = sb.pop_front();
            checks++;
            if ({gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow} !== e) begin
                errors++;
                $display("FAIL clear_abort c%0d got %h (gnt=%b) required %h", c,
                         {gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow}, gnt, e);
            end
        end
    endtask

    task automatic test_overflow_reset;
        logic [16:0] e;
        logic [18:0] t[10];
        t = '{19'b0000_0000_0_0_1_0000_0000, 19'b0000_0000_0_0_0_0000_0001,
              19'b0000_0000_0_1_0_0000_0001, 19'b0000_0000_0_0_1_0000_1011,
              19'b0000_0000_0_1_0_0000_0101, 19'b0000_0000_0_0_0_0000_1011,
              19'b0000_0000_0_0_0_0000_0100, 19'b0100_0000_0_0_0_0100_0000,
              19'b0100_0000_0_0_1_0100_0010, 19'b0100_0000_0_0_0_0100_0011};
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            drive(t[c][18:15], t[c][14:11], t[c][10], t[c][9], t[c][8], t[c][7:4], t[c][3:0]);
            e = sb.pop_front();
            checks++;
            if ({gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow} !== e) begin
                errors++;
                $display("FAIL overflow c%0d got %h (gnt=%b) required %h", c,
                         {gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow}, gnt, e);
            end
        end
        // Asynchronous reset mid-burst with the owner's request still high.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow, owner} !== '0) begin
            errors++;
            $display("FAIL async_reset got gnt=%b wen=%b wd=%h clr=%b done=%b busy=%b err=%b own=%0d required all 0",
                     gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow, owner);
        end
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        e = sb.pop_front();
        checks++;
        if ({gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow} !== e) begin
            errors++;
            $display("FAIL post_reset got %h required %h",
                     {gnt, fifo_wen, fifo_wdata, fifo_clear, clear_done, busy, err_overflow}, e);
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_burst_lock();
        test_backpressure();
        test_early_last();
        test_clear_abort();
        test_overflow_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nx_fifo_wr_arb.md
Name: nx_fifo_wr_arb

Overview:
- Round-robin write-port arbiter that shares one nx_fifo instance among N producers.
- Supports locked bursts of up to MAX_BURST beats, honours FIFO backpressure (full), sequences FIFO clear, and flags overflow.
- Sits directly in front of the FIFO's wen/wdata/clear inputs.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 1, data width per beat; matches FIFO wdata width
- MAX_BURST, 4, maximum beats per locked grant (1..16); 1 disables bursting

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NREQ  per-requester beat valid
- req_last  input  NREQ  per-requester end-of-burst marker, qualified by req
- req_data  input  NREQ*DW  packed beat data; requester i occupies bits [i*DW +: DW]
- gnt  output  NREQ  per-requester accept; beat i transfers when req[i]&gnt[i]
- clear_req  input  1  single-cycle request to flush the FIFO
- clear_done  output  1  single-cycle pulse when the flush completes
- fifo_full  input  1  from FIFO full
- fifo_overflow  input  1  from FIFO overflow
- fifo_wen  output  1  to FIFO wen
- fifo_wdata  output  DW  to FIFO wdata
- fifo_clear  output  1  to FIFO clear
- owner  output  clog2(NREQ)  index of current or last grant holder
- busy  output  1  high while in BURST or CLEAR
- err_overflow  output  1  sticky overflow flag

Behaviour:
- Reset values:
  - state=IDLE; rr_ptr=0; owner=0; beat_cnt=0.
  - gnt, fifo_wen, fifo_clear, clear_done, busy and err_overflow are all 0.
  - fifo_wdata=0 whenever fifo_wen=0.
- Interface rules:
  - gnt, fifo_wen and fifo_wdata are combinational from state and inputs. Zero-latency accept: a beat is written to the FIFO in the same cycle it is granted.
  - At most one gnt bit is high in any cycle.
  - fifo_wen = |(req & gnt).
  - fifo_wdata = the granted requester's slice.
  - gnt is never high while fifo_full=1, so the arbiter itself never causes overflow.
- IDLE:
  - Winner = first i with req[i]=1, searching from rr_ptr upward modulo NREQ.
  - If a winner exists and fifo_full=0: gnt[winner]=1 and owner<=winner.
  - If req_last[winner]=1 or MAX_BURST=1: rr_ptr<=winner+1 (mod NREQ) and stay in IDLE.
  - Otherwise: beat_cnt<=1 and go to BURST.
  - If fifo_full=1: no grant, and rr_ptr, owner and state are unchanged.
- BURST (locked to owner):
  - gnt[owner] = req[owner] & ~fifo_full. Other requesters are never granted.
  - On an accepted beat: beat_cnt++.
  - If req_last[owner]=1 or beat_cnt+1==MAX_BURST: go to IDLE and set rr_ptr<=owner+1.
  - The owner deasserting req mid-burst keeps the lock; the arbiter waits with no timeout.
  - busy=1 in this state.
- CLEAR:
  - clear_req=1 in any state has priority over arbitration and forces gnt=0 in that cycle.
  - Next cycle: state=CLEAR, fifo_clear=1 for exactly one cycle, gnt=0, busy=1.
  - Following cycle: clear_done=1 for one cycle; state=IDLE, rr_ptr=0, beat_cnt=0, err_overflow=0.
  - An in-progress burst is aborted; beats already written are flushed by the clear.
  - clear_req during CLEAR is ignored.
  - clear_req in the same cycle as clear_done starts a new clear.
- err_overflow:
  - Set to 1 on any cycle with fifo_overflow=1.
  - Cleared only by reset or a completed clear. If set and clear occur in the same cycle, set wins.
- Wrap-around: rr_ptr arithmetic is modulo NREQ, including non-power-of-2 NREQ. beat_cnt is clog2(MAX_BURST+1) bits and never exceeds MAX_BURST.
- Asynchronous reset mid-burst or mid-clear returns everything to the reset values immediately. No clear_done is produced for an interrupted clear.

Test Plan:
- Fairness: NREQ=4, MAX_BURST=1, req=4'b1111 held, fifo_full=0 for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,...; fifo_wdata tracks the granted slice each cycle.
- Burst lock: MAX_BURST=4; req0 and req2 held, req_last=0 -> gnt[0] for 4 consecutive beats, then gnt[2] for 4; never 2 bits high at once.
- Backpressure: fifo_full=1 for 3 cycles mid-burst after beat 2 -> gnt=0 and fifo_wen=0 for those 3 cycles; burst resumes with beats 3-4 on the same owner, and rr_ptr is unchanged while stalled.
- Early last: req1 asserts req_last on its 2nd beat -> return to IDLE after 2 beats; next grant goes to the next active requester above 1.
- Clear abort: clear_req pulsed during beat 2 of a burst -> gnt=0 that cycle, fifo_clear=1 next cycle, clear_done=1 the cycle after; next grant comes from rr_ptr=0.
- Overflow and reset: force fifo_overflow=1 for one cycle -> err_overflow=1 and held; then deassert rst_n mid-burst -> all outputs 0 immediately.
